// File: rtl/mem_arbiter.sv
// Two-master (CPU/DMA) arbiter for a single 16-bit memory port with bounded bursts and bus lock.
// Define MEM_ARB_RR_EN for round-robin tie-break from IDLE; otherwise CPU always wins ties.
module mem_arbiter #(
  parameter int M        = 16,
  parameter int MAXBURST = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_req,
  input  logic         dma_req,
  input  logic         cpu_we,
  input  logic         dma_we,
  input  logic [M-1:0] cpu_addr,
  input  logic [M-1:0] dma_addr,
  input  logic [M-1:0] cpu_wdata,
  input  logic [M-1:0] dma_wdata,
  input  logic         cpu_lock,
  input  logic         dma_lock,
  output logic         cpu_ack,
  output logic         dma_ack,
  output logic [M-1:0] cpu_rdata,
  output logic [M-1:0] dma_rdata,
  output logic [M-1:0] mem_addr,
  output logic [M-1:0] mem_wdata,
  output logic         mem_we,
  input  logic [M-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2
  } owner_e;

  localparam logic [8:0] MAXB9 = 9'(MAXBURST);
  localparam logic [7:0] MAXB8 = 8'(MAXBURST);

  owner_e     owner_q, owner_d;
  logic [7:0] bcnt_q, bcnt_d;
  logic       own_req_s, oth_req_s, own_lock_s, limit_s, tie_dma_s;
  owner_e     oth_s;

`ifdef MEM_ARB_RR_EN
  logic last_dma_q, last_dma_d;
  assign tie_dma_s = ~last_dma_q;
`else
  assign tie_dma_s = 1'b0;
`endif

  assign own_req_s  = (owner_q == ST_CPU) ? cpu_req  : dma_req;
  assign oth_req_s  = (owner_q == ST_CPU) ? dma_req  : cpu_req;
  assign own_lock_s = (owner_q == ST_CPU) ? cpu_lock : dma_lock;
  assign oth_s      = (owner_q == ST_CPU) ? ST_DMA   : ST_CPU;
  // Widened compare so bcnt+1 cannot wrap when MAXBURST is 255.
  assign limit_s    = ({1'b0, bcnt_q} + 9'd1) >= MAXB9;

  // Owner / burst-count next-state.
  always_comb begin
    owner_d = owner_q;
    bcnt_d  = bcnt_q;
`ifdef MEM_ARB_RR_EN
    last_dma_d = last_dma_q;
`endif
    case (owner_q)
      ST_IDLE: begin
        bcnt_d = 8'd0;
        if (cpu_req && dma_req) begin
          owner_d = tie_dma_s ? ST_DMA : ST_CPU;
        end else if (cpu_req) begin
          owner_d = ST_CPU;
        end else if (dma_req) begin
          owner_d = ST_DMA;
        end else begin
          owner_d = ST_IDLE;
        end
      end
      ST_CPU, ST_DMA: begin
        if (own_req_s && !(limit_s && oth_req_s && !own_lock_s)) begin
          owner_d = owner_q;
          bcnt_d  = (bcnt_q < MAXB8) ? (bcnt_q + 8'd1) : bcnt_q;
        end else begin
          owner_d = oth_req_s ? oth_s : ST_IDLE;
          bcnt_d  = 8'd0;
`ifdef MEM_ARB_RR_EN
          last_dma_d = (owner_q == ST_DMA);
`endif
        end
      end
      default: begin
        owner_d = ST_IDLE;
        bcnt_d  = 8'd0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= ST_IDLE;
      bcnt_q  <= 8'd0;
`ifdef MEM_ARB_RR_EN
      last_dma_q <= 1'b1;
`endif
    end else begin
      owner_q <= owner_d;
      bcnt_q  <= bcnt_d;
`ifdef MEM_ARB_RR_EN
      last_dma_q <= last_dma_d;
`endif
    end
  end

  assign cpu_ack   = (owner_q == ST_CPU) & cpu_req;
  assign dma_ack   = (owner_q == ST_DMA) & dma_req;
  assign cpu_rdata = cpu_ack ? mem_rdata : {M{1'b0}};
  assign dma_rdata = dma_ack ? mem_rdata : {M{1'b0}};

  // Memory-side mux; everything driven low while IDLE.
  always_comb begin
    mem_addr  = {M{1'b0}};
    mem_wdata = {M{1'b0}};
    mem_we    = 1'b0;
    case (owner_q)
      ST_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we & cpu_req;
      end
      ST_DMA: begin
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_we    = dma_we & dma_req;
      end
      default: begin
        mem_addr  = {M{1'b0}};
        mem_wdata = {M{1'b0}};
        mem_we    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter against a cycle-level ownership model.
module tb_mem_arbiter;

  localparam int MAXB = 8;

  logic        clk, rst;
  logic        cpu_req, dma_req, cpu_we, dma_we, cpu_lock, dma_lock;
  logic [15:0] cpu_addr, dma_addr, cpu_wdata, dma_wdata;
  logic        cpu_ack, dma_ack, mem_we;
  logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  // Model state: owner 0=idle 1=cpu 2=dma
  int m_owner;
  int m_cnt;
  bit m_last_dma;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return (a == 16'h1234) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  assign mem_rdata = mem_fn(mem_addr);

  mem_arbiter #(.M(16), .MAXBURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .dma_req(dma_req), .cpu_we(cpu_we), .dma_we(dma_we),
    .cpu_addr(cpu_addr), .dma_addr(dma_addr), .cpu_wdata(cpu_wdata), .dma_wdata(dma_wdata),
    .cpu_lock(cpu_lock), .dma_lock(dma_lock),
    .cpu_ack(cpu_ack), .dma_ack(dma_ack), .cpu_rdata(cpu_rdata), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    cpu_req = 1'b0; dma_req = 1'b0; cpu_we = 1'b0; dma_we = 1'b0;
    cpu_lock = 1'b0; dma_lock = 1'b0;
    cpu_addr = 16'h0; dma_addr = 16'h0; cpu_wdata = 16'h0; dma_wdata = 16'h0;
  endtask

  task automatic model_reset();
    m_owner = 0; m_cnt = 0; m_last_dma = 1'b1;
  endtask

  // Advance the model with the inputs present before the edge, then step past the edge.
  task automatic tick();
    bit xr, yr, xl;
    if (!rst) begin
      model_reset();
    end else if (m_owner == 0) begin
      m_cnt = 0;
      if (cpu_req && dma_req) begin
`ifdef MEM_ARB_RR_EN
        m_owner = m_last_dma ? 1 : 2;
`else
        m_owner = 1;
`endif
      end else if (cpu_req) m_owner = 1;
      else if (dma_req) m_owner = 2;
    end else begin
      xr = (m_owner == 1) ? cpu_req : dma_req;
      yr = (m_owner == 1) ? dma_req : cpu_req;
      xl = (m_owner == 1) ? cpu_lock : dma_lock;
      if (xr && !((m_cnt + 1) >= MAXB && yr && !xl)) begin
        if (m_cnt < MAXB) m_cnt = m_cnt + 1;
      end else begin
        m_last_dma = (m_owner == 2);
        m_owner = yr ? (3 - m_owner) : 0;
        m_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; clear_inputs(); model_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 16'h5555;
    tick(); tick();
    #3;
    checks++;
    if ({mem_we, cpu_ack, dma_ack} !== 3'b000)
      begin errors++; $display("FAIL reset_hold: we/cpu_ack/dma_ack=%b required 000", {mem_we, cpu_ack, dma_ack}); end
    checks++;
    if (mem_addr !== 16'h0)
      begin errors++; $display("FAIL reset_addr: got %h required 0000", mem_addr); end
    rst = 1'b1;
    #1;
    checks++;
    if (cpu_ack !== 1'b0)
      begin errors++; $display("FAIL reset_release_idle: cpu_ack=%b required 0", cpu_ack); end
    @(posedge clk); #1;
    m_owner = 1; m_cnt = 0;
    #3;
    checks++;
    if ({cpu_ack, mem_we, mem_addr} !== {1'b1, 1'b1, 16'h0100})
      begin errors++; $display("FAIL reset_first_grant: ack/we/addr=%b/%b/%h required 1/1/0100", cpu_ack, mem_we, mem_addr); end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    tick();
    #3;
    checks++;
    if ({cpu_ack, cpu_rdata, dma_rdata, mem_we} !== {1'b1, 16'hBEEF, 16'h0000, 1'b0})
      begin errors++; $display("FAIL cpu_read: ack=%b rdata=%h dma_rdata=%h we=%b required 1 BEEF 0000 0", cpu_ack, cpu_rdata, dma_rdata, mem_we); end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_burst();
    cpu_req = 1'b1;
    tick();
    dma_req = 1'b1;
    for (int k = 0; k < 32; k++) begin
      cpu_addr = 16'($urandom); dma_addr = 16'($urandom);
      cpu_we = 1'($urandom); dma_we = 1'($urandom);
      #3;
      checks++;
      if ({cpu_ack, dma_ack} !== (((k / MAXB) % 2 == 0) ? 2'b10 : 2'b01))
        begin errors++; $display("FAIL burst_cycle%0d: cpu/dma ack=%b%b", k, cpu_ack, dma_ack); end
      tick();
    end
  endtask

  task automatic test_lock();
    cpu_lock = 1'b1;
    for (int i = 0; i < 22; i++) begin
      if (i == 20) cpu_lock = 1'b0;
      #3;
      checks++;
      if (i <= 20 && {cpu_ack, dma_ack} !== 2'b10)
        begin errors++; $display("FAIL lock_cycle%0d: cpu/dma ack=%b%b required 10", i, cpu_ack, dma_ack); end
      else if (i == 21 && {cpu_ack, dma_ack} !== 2'b01)
        begin errors++; $display("FAIL lock_handover: cpu/dma ack=%b%b required 01", cpu_ack, dma_ack); end
      tick();
    end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_tie();
    logic [1:0] exp2;
    rst = 1'b0; #2; model_reset(); rst = 1'b1;
    clear_inputs();
    cpu_req = 1'b1; dma_req = 1'b1;
    tick();
    #3;
    checks++;
    if ({cpu_ack, dma_ack} !== 2'b10)
      begin errors++; $display("FAIL tie_first: cpu/dma ack=%b%b required 10", cpu_ack, dma_ack); end
    clear_inputs();
    tick();
    #3;
    checks++;
    if ({cpu_ack, dma_ack, mem_we} !== 3'b000)
      begin errors++; $display("FAIL tie_idle_gap: ack/ack/we=%b required 000", {cpu_ack, dma_ack, mem_we}); end
    cpu_req = 1'b1; dma_req = 1'b1;
    tick();
    #3;
`ifdef MEM_ARB_RR_EN
    exp2 = 2'b01;
`else
    exp2 = 2'b10;
`endif
    checks++;
    if ({cpu_ack, dma_ack} !== exp2)
      begin errors++; $display("FAIL tie_second: cpu/dma ack=%b%b required %b", cpu_ack, dma_ack, exp2); end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_reset_mid_write();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0040; dma_wdata = 16'h00FF;
    tick();
    #3;
    checks++;
    if ({dma_ack, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h0040, 16'h00FF})
      begin errors++; $display("FAIL midwrite_pre: ack/we/addr/wdata=%b/%b/%h/%h required 1/1/0040/00FF", dma_ack, mem_we, mem_addr, mem_wdata); end
    rst = 1'b0; model_reset();
    #1;
    checks++;
    if ({dma_ack, mem_we, mem_addr, mem_wdata} !== {1'b0, 1'b0, 16'h0, 16'h0})
      begin errors++; $display("FAIL midwrite_reset: ack/we/addr/wdata=%b/%b/%h/%h required all 0", dma_ack, mem_we, mem_addr, mem_wdata); end
    tick();
    rst = 1'b1;
    tick();
    #3;
    checks++;
    if ({dma_ack, cpu_ack, mem_we} !== 3'b101)
      begin errors++; $display("FAIL midwrite_regrant: dma/cpu ack/we=%b required 101", {dma_ack, cpu_ack, mem_we}); end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_random();
    logic [82:0] exp_v, got_v;
    logic        e_cack, e_dack, e_we;
    logic [15:0] e_addr, e_wd;
    for (int n = 0; n < 400; n++) begin
      cpu_req = ($urandom_range(0, 3) != 0); dma_req = ($urandom_range(0, 3) != 0);
      cpu_we = 1'($urandom); dma_we = 1'($urandom);
      cpu_lock = ($urandom_range(0, 7) == 0); dma_lock = ($urandom_range(0, 7) == 0);
      cpu_addr = 16'($urandom); dma_addr = 16'($urandom);
      cpu_wdata = 16'($urandom); dma_wdata = 16'($urandom);
      #3;
      e_cack = (m_owner == 1) && cpu_req;
      e_dack = (m_owner == 2) && dma_req;
      e_addr = (m_owner == 1) ? cpu_addr : (m_owner == 2) ? dma_addr : 16'h0;
      e_wd   = (m_owner == 1) ? cpu_wdata : (m_owner == 2) ? dma_wdata : 16'h0;
      e_we   = (m_owner == 1) ? (cpu_we && cpu_req) : (m_owner == 2) ? (dma_we && dma_req) : 1'b0;
      exp_v = {e_cack, e_dack, e_we, e_addr, e_wd,
               e_cack ? mem_fn(e_addr) : 16'h0, e_dack ? mem_fn(e_addr) : 16'h0};
      got_v = {cpu_ack, dma_ack, mem_we, mem_addr, mem_wdata, cpu_rdata, dma_rdata};
      checks++;
      if (got_v !== exp_v)
        begin errors++; $display("FAIL random_cycle%0d: got %h required %h", n, got_v, exp_v); end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_cpu_read();
    test_burst();
    test_lock();
    test_tie();
    test_reset_mid_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter that shares the single 16-bit memory port between the RCPU core and a DMA engine. It tracks which master owns the port, enforces a bounded burst length so neither master starves the other, honours a bus-lock request for atomic sequences, and muxes address, write data and write-enable onto the memory. It sits between the CPU/DMA memory interfaces and the memory array; read data is a combinational pass-through from memory, as the CPU already expects.

## Interface
- M, 16: data and address bus width
- MAXBURST, 8: maximum acked accesses per ownership before forced hand-over; 1..255
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- cpu_req / dma_req  input  1  access request; held until acked
- cpu_we / dma_we  input  1  1 = write, 0 = read
- cpu_addr / dma_addr  input  M  access address
- cpu_wdata / dma_wdata  input  M  write data
- cpu_lock / dma_lock  input  1  owner keeps the port past MAXBURST while high
- cpu_ack / dma_ack  output  1  access performed this cycle
- cpu_rdata / dma_rdata  output  M  read data, valid while matching ack high
- mem_addr  output  M  memory address
- mem_wdata  output  M  memory write data
- mem_we  output  1  memory write enable
- mem_rdata  input  M  memory read data, combinational from mem_addr

## Operation
- Owner state: IDLE, OWN_CPU, OWN_DMA. Registers: owner, burst count bcnt (8 bits), last (last non-IDLE owner).
- Datapath: in OWN_X, mem_addr/mem_wdata = X's signals, mem_we = X_we & X_req; in IDLE all mem outputs 0.
- X_ack = (owner == OWN_X) & X_req, combinational. X_rdata = mem_rdata when X_ack, else 0.
- Each acked cycle increments bcnt, saturating at MAXBURST; bcnt clears on every owner change.
- Next owner from OWN_X, other master Y:
  - X_req high, and not (bcnt+1 >= MAXBURST & Y_req & !X_lock): stay OWN_X.
  - X_req high, burst limit reached, Y_req high, X_lock low: go OWN_Y (current access still acked).
  - X_req low, Y_req high: go OWN_Y.
  - both low: go IDLE.
- From IDLE: one request -> that owner; both -> tie-break (see Configuration).
- last updates to the owner being left on each OWN_X -> other transition.
- Lock held by owner overrides burst limit indefinitely; lock from the non-owner is ignored.
- A master dropping req mid-burst loses ownership; its next req re-arbitrates.

## Timing
- Reset (rst low, asynchronous): owner=IDLE, bcnt=0, last=OWN_DMA; all acks, rdata, mem_* = 0 immediately. In-flight write is dropped (mem_we falls with rst).
- Grant latency from IDLE: req at cycle N -> ack at cycle N+1.
- Hand-over latency: zero idle cycles; Y acked the cycle after X's last ack.
- Single-master throughput: one access per cycle indefinitely (burst limit only acts if other master requests).
- At most one ack high in any cycle; mem_we never high without the owner's ack.

## Configuration
- MEM_ARB_RR_EN defined: IDLE tie (both req) goes to the master that is not last (round-robin); first tie after reset goes to CPU.
- MEM_ARB_RR_EN undefined: IDLE tie always goes to CPU; last register is removed. Burst limit and lock behave identically in both builds.

## Test plan
- Reset: hold rst=0 with cpu_req=1, cpu_we=1 -> mem_we=0, cpu_ack=0; release at cycle 0 -> cpu_ack=1 at cycle 1, mem_addr=cpu_addr.
- CPU read: cpu_addr=0x1234, memory returns 0xBEEF -> cpu_rdata=0xBEEF with cpu_ack same cycle, dma_rdata=0.
- Burst limit, MAXBURST=8: CPU and DMA requesting continuously from CPU ownership -> exactly 8 cpu_acks, then 8 dma_acks, alternating, no gap cycles, never both acks high.
- Lock: repeat previous with cpu_lock=1 for 20 cycles -> 20 consecutive cpu_acks, dma_ack at cycle after cpu_lock falls (first ack after bcnt saturated).
- Tie from IDLE: both req simultaneously twice with an IDLE cycle between -> RR build: CPU then DMA; non-RR build: CPU then CPU.
- Reset mid-write: DMA writing 0x00FF to 0x0040, drop rst in same cycle -> mem_we=0 immediately, owner IDLE, first grant after release per IDLE rules.
